// File: rtl/conv_pass_sequencer.sv
// conv_pass_sequencer: loads filter and IF words from SRAM into the core FIFOs, starts the core,
// drains results to the result port and pulses done. Defining SEQ_TIMEOUT_EN adds a DRAIN watchdog that drives err.
module conv_pass_sequencer #(
    parameter int ADDR_W = 12,
    parameter int IF_W   = 18,
    parameter int FILT_W = 8,
    parameter int OUT_W  = 17,
    parameter int TMO_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    input  logic [ADDR_W-1:0] cfg_filt_base,
    input  logic [ADDR_W-1:0] cfg_filt_cnt,
    input  logic [ADDR_W-1:0] cfg_if_base,
    input  logic [ADDR_W-1:0] cfg_if_cnt,
    input  logic [ADDR_W-1:0] cfg_out_cnt,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [IF_W-1:0]   mem_rdata,
    output logic              filt_wen,
    output logic [FILT_W-1:0] filt_din,
    input  logic              filt_full,
    output logic              if_wen,
    output logic [IF_W-1:0]   if_din,
    input  logic              if_full,
    output logic              core_start,
    input  logic              outbuf_empty,
    input  logic [OUT_W-1:0]  outbuf_dout,
    output logic              outbuf_ren,
    output logic              res_valid,
    output logic [OUT_W-1:0]  res_data,
    input  logic              res_ready,
    output logic              busy,
    output logic              done,
    output logic              err
);
    // state    | meaning
    // S_IDLE   | waiting for go; cfg captured on the go cycle
    // S_LOAD_F | fetching filter words into the filter FIFO
    // S_START  | one-cycle core_start pulse
    // S_STREAM | fetching IF words while draining results
    // S_DRAIN  | draining the remaining results
    // S_FIN    | one-cycle done pulse
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_F, S_START, S_STREAM, S_DRAIN, S_FIN
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] filt_base_q, filt_cnt_q, if_base_q, if_cnt_q, out_cnt_q;
    logic [ADDR_W-1:0] issued, written, rcv;
    logic [ADDR_W-1:0] fetch_base, fetch_cnt;
    logic              pend;
    logic              fetch_phase, drain_phase, fetch_full, fetch_done;
    logic              issue, wr, pop, tmo_hit;

    // One SRAM read in flight at most; the write lands the cycle after the issue.
    always_comb begin
        fetch_phase = (state == S_LOAD_F) || (state == S_STREAM);
        drain_phase = (state == S_STREAM) || (state == S_DRAIN);
        fetch_base  = (state == S_LOAD_F) ? filt_base_q : if_base_q;
        fetch_cnt   = (state == S_LOAD_F) ? filt_cnt_q  : if_cnt_q;
        fetch_full  = (state == S_LOAD_F) ? filt_full   : if_full;
        issue       = fetch_phase && !pend && !fetch_full && (issued < fetch_cnt);
        wr          = fetch_phase && pend;
        fetch_done  = (written == fetch_cnt);
        res_valid   = drain_phase && !outbuf_empty && (rcv < out_cnt_q);
        pop         = res_valid && res_ready;
    end

    always_comb begin
        mem_rd_en  = issue;
        mem_addr   = issue ? (fetch_base + issued) : '0;
        filt_wen   = wr && (state == S_LOAD_F);
        filt_din   = filt_wen ? mem_rdata[FILT_W-1:0] : '0;
        if_wen     = wr && (state == S_STREAM);
        if_din     = if_wen ? mem_rdata : '0;
        res_data   = res_valid ? outbuf_dout : '0;
        outbuf_ren = pop;
        busy       = (state != S_IDLE);
    end

    always_comb begin
        state_nxt  = state;
        core_start = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE:   if (go) state_nxt = S_LOAD_F;
            S_LOAD_F: if (fetch_done) state_nxt = S_START;
            S_START: begin
                core_start = 1'b1;
                state_nxt  = S_STREAM;
            end
            S_STREAM: if (fetch_done) state_nxt = S_DRAIN;
            S_DRAIN:  if ((rcv == out_cnt_q) || tmo_hit) state_nxt = S_FIN;
            S_FIN: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            filt_base_q <= '0;
            filt_cnt_q  <= '0;
            if_base_q   <= '0;
            if_cnt_q    <= '0;
            out_cnt_q   <= '0;
            issued      <= '0;
            written     <= '0;
            rcv         <= '0;
            pend        <= 1'b0;
        end else begin
            state <= state_nxt;
            pend  <= issue;
            if (state == S_IDLE) begin
                if (go) begin
                    filt_base_q <= cfg_filt_base;
                    filt_cnt_q  <= cfg_filt_cnt;
                    if_base_q   <= cfg_if_base;
                    if_cnt_q    <= cfg_if_cnt;
                    out_cnt_q   <= cfg_out_cnt;
                end
                issued  <= '0;
                written <= '0;
                rcv     <= '0;
            end else if (state == S_START) begin
                // filter and IF fetches share the issue/write counters
                issued  <= '0;
                written <= '0;
            end else begin
                if (issue) issued <= issued + ADDR_W'(1);
                if (wr) written <= written + ADDR_W'(1);
            end
            if (pop) rcv <= rcv + ADDR_W'(1);
        end
    end

`ifdef SEQ_TIMEOUT_EN
    logic [TMO_W-1:0] tmo;
    logic             err_q;

    assign tmo_hit = (state == S_DRAIN) && (&tmo) && !pop && (rcv != out_cnt_q);
    assign err     = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo   <= '0;
            err_q <= 1'b0;
        end else begin
            if ((state == S_DRAIN) && !pop) tmo <= tmo + TMO_W'(1);
            else tmo <= '0;
            if ((state == S_IDLE) && go) err_q <= 1'b0;
            else if (tmo_hit) err_q <= 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign err     = 1'b0;
`endif

endmodule
